// File: rtl/ex2_stage.sv
// Second execute stage: registers EX1 results and owns the HI/LO accumulator.
// MADD/MSUB split the 64-bit accumulate over two cycles, raising Busy during the upper half.
module ex2_stage (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        InValid,
  input  logic [63:0] Out,
  input  logic [3:0]  Flags,
  input  logic        RegWriteIn,
  input  logic        MemWriteIn,
  input  logic        ACCEn,
  input  logic [1:0]  AccOp,
  input  logic        AccSel,
  input  logic [4:0]  RegDestIn,
  input  logic [31:0] StoreDataIn,
  output logic        Busy,
  output logic        OutValid,
  output logic [31:0] Result,
  output logic [3:0]  FlagsOut,
  output logic        RegWriteOut,
  output logic        MemWriteOut,
  output logic [4:0]  RegDestOut,
  output logic [31:0] StoreDataOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, ACC_HI} state_t;

  state_t      state;
  logic        carry;
  logic        acc_sub;
  logic [31:0] hi_word;
  logic        valid;
  logic [32:0] lo_sum;
  logic [32:0] hi_sum;

  // Bit 32 of each sum is the carry for add and the borrow for subtract.
  always_comb begin
    valid  = InValid & ~Flush;
    lo_sum = AccOp[1] ? ({1'b0, LO} - {1'b0, Out[31:0]})
                      : ({1'b0, LO} + {1'b0, Out[31:0]});
    hi_sum = acc_sub  ? ({1'b0, HI} - {1'b0, hi_word} - {32'd0, carry})
                      : ({1'b0, HI} + {1'b0, hi_word} + {32'd0, carry});
  end

  assign Busy = (state == ACC_HI);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      carry        <= 1'b0;
      acc_sub      <= 1'b0;
      hi_word      <= '0;
      HI           <= '0;
      LO           <= '0;
      OutValid     <= 1'b0;
      Result       <= '0;
      FlagsOut     <= '0;
      RegWriteOut  <= 1'b0;
      MemWriteOut  <= 1'b0;
      RegDestOut   <= '0;
      StoreDataOut <= '0;
    end else if (!Stall) begin
      case (state)
        IDLE: begin
          Result       <= Out[31:0];
          FlagsOut     <= Flags;
          RegDestOut   <= RegDestIn;
          StoreDataOut <= StoreDataIn;
          OutValid     <= valid;
          RegWriteOut  <= valid & RegWriteIn;
          MemWriteOut  <= valid & MemWriteIn;
          if (valid && ACCEn) begin
            RegWriteOut <= 1'b0;
            MemWriteOut <= 1'b0;
            case (AccOp)
              2'b00: {HI, LO} <= Out;
              2'b01, 2'b10: begin
                LO       <= lo_sum[31:0];
                carry    <= lo_sum[32];
                hi_word  <= Out[63:32];
                acc_sub  <= AccOp[1];
                OutValid <= 1'b0;
                state    <= ACC_HI;
              end
              default: begin
                Result      <= AccSel ? HI : LO;
                RegWriteOut <= RegWriteIn;
              end
            endcase
          end
        end
        ACC_HI: begin
          // LO was committed on the first edge; Flush and upstream inputs are ignored here.
          HI          <= hi_sum[31:0];
          Result      <= LO;
          FlagsOut    <= {hi_sum[32], (hi_sum[31:0] == '0) && (LO == '0), 1'b0, hi_sum[31]};
          OutValid    <= 1'b1;
          RegWriteOut <= 1'b0;
          MemWriteOut <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex2_stage.sv
// Directed bench for ex2_stage: expected outputs are queued at issue and checked when OutValid rises.
module tb_ex2_stage;

  logic        Clock, nReset, Stall, Flush, InValid;
  logic [63:0] Out;
  logic [3:0]  Flags;
  logic        RegWriteIn, MemWriteIn, ACCEn;
  logic [1:0]  AccOp;
  logic        AccSel;
  logic [4:0]  RegDestIn;
  logic [31:0] StoreDataIn;
  logic        Busy, OutValid;
  logic [31:0] Result;
  logic [3:0]  FlagsOut;
  logic        RegWriteOut, MemWriteOut;
  logic [4:0]  RegDestOut;
  logic [31:0] StoreDataOut, HI, LO;

  ex2_stage dut (
    .Clock(Clock), .nReset(nReset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .Out(Out), .Flags(Flags), .RegWriteIn(RegWriteIn), .MemWriteIn(MemWriteIn),
    .ACCEn(ACCEn), .AccOp(AccOp), .AccSel(AccSel), .RegDestIn(RegDestIn),
    .StoreDataIn(StoreDataIn), .Busy(Busy), .OutValid(OutValid), .Result(Result),
    .FlagsOut(FlagsOut), .RegWriteOut(RegWriteOut), .MemWriteOut(MemWriteOut),
    .RegDestOut(RegDestOut), .StoreDataOut(StoreDataOut), .HI(HI), .LO(LO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    logic        rw, mw;
    logic [4:0]  rd;
    logic [31:0] sd, hi, lo;
    logic        cf, cm, cr;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  int          valid_cnt = 0;
  logic [63:0] m_acc;
  logic [63:0] saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    Stall = 0; Flush = 0; InValid = 0; ACCEn = 0; AccOp = 2'b00; AccSel = 0;
    RegWriteIn = 0; MemWriteIn = 0; Out = '0; Flags = '0; RegDestIn = '0; StoreDataIn = '0;
  endtask

  task automatic issue(input logic v, input logic fl, input logic acc, input logic [1:0] op,
                       input logic sel, input logic rw, input logic mw, input logic [63:0] o,
                       input logic [3:0] f, input logic [4:0] rd, input logic [31:0] sd);
    exp_t        e;
    logic [64:0] r;
    idle_in();
    InValid = v; Flush = fl; ACCEn = acc; AccOp = op; AccSel = sel;
    RegWriteIn = rw; MemWriteIn = mw; Out = o; Flags = f; RegDestIn = rd; StoreDataIn = sd;
    if (v && !fl) begin
      e.result = o[31:0]; e.flags = f; e.rw = rw; e.mw = mw; e.rd = rd; e.sd = sd;
      e.cf = 1; e.cm = 1; e.cr = 1;
      if (acc) begin
        e.rw = 0; e.mw = 0; e.cf = 0; e.cm = 0; e.cr = 0;
        case (op)
          2'd0: m_acc = o;
          2'd1, 2'd2: begin
            r = (op == 2'd1) ? ({1'b0, m_acc} + {1'b0, o}) : ({1'b0, m_acc} - {1'b0, o});
            m_acc = r[63:0];
            e.result = m_acc[31:0];
            e.flags = {r[64], m_acc == 64'd0, 1'b0, m_acc[63]};
            e.cf = 1; e.cm = 1;
          end
          default: begin
            e.result = sel ? m_acc[63:32] : m_acc[31:0];
            e.rw = rw;
          end
        endcase
      end
      e.hi = m_acc[63:32]; e.lo = m_acc[31:0];
      sb.push_back(e);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge Clock);
    #1;
    if (Busy === 1'b1) busy_cnt++;
    if (OutValid === 1'b1) begin
      valid_cnt++;
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed OutValid=1 expected no pending result");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", Result, e.result);
        chk("regwrite", RegWriteOut, e.rw);
        chk("hi", HI, e.hi);
        chk("lo", LO, e.lo);
        if (e.cf) chk("flags", FlagsOut, e.flags);
        if (e.cm) chk("memwrite", MemWriteOut, e.mw);
        if (e.cr) begin
          chk("regdest", RegDestOut, e.rd);
          chk("storedata", StoreDataOut, e.sd);
        end
      end
    end
  endtask

  initial begin
    idle_in();
    nReset = 0;
    m_acc = '0;
    #12;
    chk("rst_valid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_result", Result, 0);
    chk("rst_hilo", {HI, LO}, 0);
    @(negedge Clock);
    nReset = 1;

    // Plain pass-through ops
    issue(1, 0, 0, 2'd0, 0, 1, 1, 64'hdead_beef_1234_5678, 4'b1010, 5'd7, 32'hcafe_f00d);
    cycle();
    issue(1, 0, 0, 2'd0, 0, 0, 1, 64'h0, 4'b0101, 5'd31, 32'h1);
    cycle();

    // Load then move-from
    issue(1, 0, 1, 2'd0, 0, 1, 1, 64'h0000_0001_FFFF_FFFF, 4'h0, 5'd3, 32'h0);
    cycle();
    issue(1, 0, 1, 2'd3, 1, 1, 0, 64'h0, 4'h0, 5'd4, 32'h0);
    cycle();
    issue(1, 0, 1, 2'd3, 0, 1, 0, 64'h0, 4'h0, 5'd5, 32'h0);
    cycle();

    // MADD with carry from LO into HI; Flush during ACC_HI is ignored
    issue(1, 0, 1, 2'd0, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 4'h0, 5'd0, 32'h0);
    cycle();
    issue(1, 0, 1, 2'd1, 0, 1, 0, 64'd1, 4'hf, 5'd0, 32'h0);
    cycle();
    chk("madd_busy", Busy, 1);
    chk("madd_bubble", OutValid, 0);
    chk("madd_lo_first", LO, 32'h0);
    idle_in();
    Flush = 1; InValid = 1; ACCEn = 1; Out = '1;
    cycle();
    chk("madd_busy_fall", Busy, 0);
    issue(1, 0, 1, 2'd3, 1, 1, 0, 64'h0, 4'h0, 5'd9, 32'h0);
    cycle();

    // MSUB with borrow
    issue(1, 0, 1, 2'd0, 0, 0, 0, 64'd0, 4'h0, 5'd0, 32'h0);
    cycle();
    issue(1, 0, 1, 2'd2, 0, 0, 0, 64'd1, 4'h0, 5'd0, 32'h0);
    cycle();
    chk("msub_busy", Busy, 1);
    idle_in();
    cycle();

    // Stall held for 3 cycles in ACC_HI
    issue(1, 0, 1, 2'd0, 0, 0, 0, 64'h0000_0002_8000_0000, 4'h0, 5'd0, 32'h0);
    cycle();
    busy_cnt = 0;
    valid_cnt = 0;
    issue(1, 0, 1, 2'd1, 0, 0, 0, 64'h0000_0001_8000_0000, 4'h0, 5'd0, 32'h0);
    cycle();
    idle_in();
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_hi_hold", HI, 32'd2);
      chk("stall_no_valid", OutValid, 0);
    end
    Stall = 0;
    cycle();
    idle_in();
    cycle();
    chk("stall_busy_cycles", busy_cnt, 4);
    chk("stall_valid_pulses", valid_cnt, 1);

    // Flushed load and InValid=0 both produce bubbles
    saved = m_acc;
    issue(1, 1, 1, 2'd0, 0, 1, 1, 64'h1234_5678_9abc_def0, 4'h0, 5'd1, 32'h0);
    cycle();
    chk("flush_valid", OutValid, 0);
    chk("flush_ctl", {RegWriteOut, MemWriteOut}, 0);
    chk("flush_hilo", {HI, LO}, saved);
    issue(0, 0, 0, 2'd0, 0, 1, 1, 64'h55, 4'h3, 5'd2, 32'h7);
    cycle();
    chk("inval_valid", OutValid, 0);
    chk("inval_ctl", {RegWriteOut, MemWriteOut}, 0);
    chk("inval_hilo", {HI, LO}, saved);

    // Asynchronous reset in ACC_HI with HI = 5
    issue(1, 0, 1, 2'd0, 0, 0, 0, 64'h0000_0005_0000_0000, 4'h0, 5'd0, 32'h0);
    cycle();
    issue(1, 0, 1, 2'd1, 0, 0, 0, 64'd3, 4'h0, 5'd0, 32'h0);
    cycle();
    chk("pre_rst_busy", Busy, 1);
    idle_in();
    #2;
    nReset = 0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_hilo", {HI, LO}, 0);
    chk("arst_valid", OutValid, 0);
    chk("arst_outs", {Result, FlagsOut, RegWriteOut, MemWriteOut, RegDestOut}, 0);
    sb.delete();
    m_acc = '0;
    @(negedge Clock);
    nReset = 1;
    issue(1, 0, 1, 2'd3, 1, 1, 0, 64'h0, 4'h0, 5'd6, 32'h0);
    cycle();
    idle_in();
    cycle();

    chk("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex2_stage.md
# ex2_stage

Second execute stage: registers the 64-bit result, flags and write controls produced by the first execute stage. Owns the architectural HI/LO accumulator pair, which implements the MULT/MADD/MSUB/MFHI/MFLO semantics. The 64-bit accumulate is split over two cycles; during the second cycle the stage raises `Busy` to hold the upstream pipeline. Sits between the first execute stage and the memory stage.

## Interface
- No parameters.
- `Clock` in 1: rising-edge clock.
- `nReset` in 1: asynchronous, active-low reset.
- `Stall` in 1: downstream stall; hold the output register and FSM.
- `Flush` in 1: squash the instruction being captured this cycle.
- `InValid` in 1: upstream instruction valid.
- `Out` in 64: execute result from EX1 (product in [63:0]).
- `Flags` in 4: {C,Z,O,N} from EX1.
- `RegWriteIn`, `MemWriteIn`, `ACCEn` in 1 each: write controls and accumulator op enable.
- `AccOp` in 2: 00 load {HI,LO}, 01 add (MADD), 10 subtract (MSUB), 11 move-from.
- `AccSel` in 1: source for move-from; 0 = LO, 1 = HI.
- `RegDestIn` in 5: destination register.
- `StoreDataIn` in 32: store data, passed through.
- `Busy` out 1: upstream must hold its register while high.
- `OutValid` out 1: output register holds a valid instruction.
- `Result` out 32: result forwarded to the memory stage.
- `FlagsOut` out 4: registered {C,Z,O,N}.
- `RegWriteOut`, `MemWriteOut` out 1 each.
- `RegDestOut` out 5; `StoreDataOut` out 32.
- `HI`, `LO` out 32 each: accumulator state.

## Operation
- FSM states: IDLE and ACC_HI. `Busy` = (state == ACC_HI), decoded from registered state only.
- **Capture.** Capture occurs in IDLE when `Stall` = 0.
  - Captured controls are gated: valid = `InValid` & !`Flush`.
  - A gated-off capture loads a bubble: `OutValid`, `RegWriteOut` and `MemWriteOut` = 0, and HI/LO are not modified.
- **Non-accumulator op** (`ACCEn` = 0):
  - `Result` <= `Out`[31:0]; `FlagsOut` <= `Flags`.
  - Controls, `RegDestOut` and `StoreDataOut` are registered as-is.
- **AccOp 00:** {HI,LO} <= `Out`. `Result` <= `Out`[31:0]; `RegWriteOut` <= 0; `OutValid` <= 1.
- **AccOp 01/10, first edge:**
  - LO <= LO ± `Out`[31:0], using 33-bit arithmetic.
  - Internal carry register <= bit 32 of that result. For subtract this is the borrow, i.e. the inverted carry.
  - `Out`[63:32] is latched internally. State -> ACC_HI.
  - Output register loads a bubble (`OutValid` = 0).
- **ACC_HI with `Stall` = 0:**
  - HI <= HI ± latched upper word ± carry/borrow. State -> IDLE.
  - Output register: `OutValid` = 1, `RegWriteOut` = 0, `MemWriteOut` = 0, `Result` = new LO.
  - `FlagsOut` = {final carry/borrow, (new HI == 0 && LO == 0), 0, new HI[31]}.
- **ACC_HI with `Stall` = 1:** HI, FSM and outputs all hold.
- **AccOp 11:** `Result` <= `AccSel` ? HI : LO. HI and LO are the values before the edge. `RegWriteOut` <= `RegWriteIn`.
- **Flush in ACC_HI:** `Flush` is ignored. The accumulate in progress has already committed LO and always completes.
- **Inputs in ACC_HI:** upstream inputs are don't-care. Upstream holds them because `Busy` = 1.
- **Wrap-around:** accumulator arithmetic is modulo 2^64. No overflow trap; O is always 0 for accumulator ops.
- **Reset:**
  - All outputs 0; HI, LO, carry and latched word all 0; state IDLE.
  - Reset asserted in ACC_HI abandons the op: LO keeps no partial result, because it is reset to 0.

## Timing
- Normal and AccOp 00/11 ops: 1-cycle latency, fully pipelined.
- MADD/MSUB: 2 cycles of occupancy.
  - Result valid on the second edge after capture.
  - `Busy` is high for exactly 1 cycle, plus any cycles where `Stall` = 1.
- Back-to-back MADD then MFHI: MFHI is captured on the cycle `Busy` falls and reads the completed HI. No forwarding hazard.
- `Stall` and `Busy` together: `Stall` has priority and the whole stage freezes.

## Test plan
- **Reset:**
  - Stimulus: drive `nReset` = 0 mid-cycle, with state in ACC_HI and HI = 5.
  - Response: outputs, HI and LO go to 0 immediately and asynchronously; `Busy` = 0.
- **Load, then move-from:**
  - Stimulus: AccOp 00 with `Out` = 64'h0000_0001_FFFF_FFFF, then AccOp 11 with AccSel = 1.
  - Response: HI = 1, LO = FFFF_FFFF; the second op gives `Result` = 1 with `RegWriteOut` = 1.
- **MADD carry:**
  - Stimulus: {HI,LO} = {0, FFFF_FFFF}, MADD with `Out` = 1.
  - Response: `Busy` = 1 for one cycle; final HI = 1, LO = 0.
  - `FlagsOut`: C = 0, Z = 0, N = 0.
- **MSUB borrow:**
  - Stimulus: {HI,LO} = {0, 0}, MSUB with `Out` = 1.
  - Response: HI = LO = FFFF_FFFF; N = 1.
- **Stall during ACC_HI:**
  - Stimulus: MADD, then `Stall` = 1 for 3 cycles in ACC_HI.
  - Response: `Busy` stays high for 4 cycles total; HI updates once; `OutValid` pulses once.
- **Flush and InValid = 0:**
  - Stimulus: `Flush` = 1 on AccOp 00 capture; `InValid` = 0 with `RegWriteIn` = 1.
  - Response: HI/LO unchanged; `OutValid`, `RegWriteOut` and `MemWriteOut` all 0.
